// File: rtl/alu_issue_if.sv
// Issue-stage bundle: fetch handshake, ALU issue payload and writeback port.
// slave = issue stage, master = environment driving fetch/ALU/writeback.
interface alu_issue_if;
   localparam int unsigned XLEN = 16;
   localparam int unsigned RW   = 3;
   localparam int unsigned IMMW = 6;

   logic            instr_valid_i;
   logic [XLEN-1:0] instr_i;
   logic            instr_ready_o;
   logic            issue_valid_o;
   logic            issue_ready_i;
   logic [XLEN-1:0] rs1_data_o;
   logic [XLEN-1:0] rs2_data_o;
   logic [IMMW-1:0] imm_o;
   logic [2:0]      op_o;
   logic [3:0]      func4_o;
   logic [RW-1:0]   rd_o;
   logic            illegal_o;
   logic            wb_valid_i;
   logic [RW-1:0]   wb_rd_i;
   logic [XLEN-1:0] wb_data_i;

   modport slave (
      input  instr_valid_i, instr_i, issue_ready_i, wb_valid_i, wb_rd_i, wb_data_i,
      output instr_ready_o, issue_valid_o, rs1_data_o, rs2_data_o, imm_o, op_o,
             func4_o, rd_o, illegal_o
   );

   modport master (
      output instr_valid_i, instr_i, issue_ready_i, wb_valid_i, wb_rd_i, wb_data_i,
      input  instr_ready_o, issue_valid_o, rs1_data_o, rs2_data_o, imm_o, op_o,
             func4_o, rd_o, illegal_o
   );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: decode, 8x16 regfile, busy scoreboard, registered issue slot.
// Optional ALU_ISSUE_BYPASS_EN forwards same-cycle writeback into operand reads.
module alu_issue (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.slave  bus
);
   localparam int unsigned XLEN  = 16;
   localparam int unsigned NREGS = 8;
   localparam int unsigned RW    = 3;
   localparam int unsigned IMMW  = 6;

   localparam logic [2:0] OP_R     = 3'b000;
   localparam logic [2:0] OP_I     = 3'b001;
   localparam logic [3:0] FUNC_ADD = 4'h0;

   // Decoded fields
   logic [2:0]      dec_op;
   logic [RW-1:0]   dec_rd;
   logic [RW-1:0]   dec_rs1;
   logic [RW-1:0]   dec_rs2;
   logic [3:0]      dec_func4;
   logic [IMMW-1:0] dec_imm;
   logic            dec_is_r;
   logic            dec_is_i;
   logic            dec_legal;

   // State
   logic [XLEN-1:0]  rf_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic             issue_valid_q, issue_valid_d;
   logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
   logic [IMMW-1:0]  imm_q, imm_d;
   logic [2:0]       op_q, op_d;
   logic [3:0]       func4_q, func4_d;
   logic [RW-1:0]    rd_q, rd_d;
   logic             illegal_q, illegal_d;

   // Combinational helpers
   logic [NREGS-1:0] wb_clr_mask;
   logic [NREGS-1:0] busy_eff;
   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;
   logic             hazard;
   logic             slot_free;
   logic             instr_ready;
   logic             accept;

   always_comb begin
      dec_op    = bus.instr_i[15:13];
      dec_rd    = bus.instr_i[12:10];
      dec_rs1   = bus.instr_i[9:7];
      dec_rs2   = bus.instr_i[6:4];
      dec_is_r  = (dec_op == OP_R);
      dec_is_i  = (dec_op == OP_I);
      dec_legal = dec_is_r | dec_is_i;
      dec_func4 = dec_is_r ? bus.instr_i[3:0] : FUNC_ADD;
      dec_imm   = dec_is_i ? bus.instr_i[6:1] : '0;
   end

   always_comb begin
      wb_clr_mask = '0;
      if (bus.wb_valid_i) wb_clr_mask = NREGS'(1) << bus.wb_rd_i;
   end

   // Operand read; r0 entry is never written so it always reads zero
`ifdef ALU_ISSUE_BYPASS_EN
   always_comb begin
      busy_eff = busy_q & ~wb_clr_mask;
      rs1_val  = rf_q[dec_rs1];
      rs2_val  = rf_q[dec_rs2];
      if (bus.wb_valid_i && (bus.wb_rd_i == dec_rs1) && (dec_rs1 != '0)) rs1_val = bus.wb_data_i;
      if (bus.wb_valid_i && (bus.wb_rd_i == dec_rs2) && (dec_rs2 != '0)) rs2_val = bus.wb_data_i;
      if (!dec_is_r) rs2_val = '0;
   end
`else
   always_comb begin
      busy_eff = busy_q;
      rs1_val  = rf_q[dec_rs1];
      rs2_val  = dec_is_r ? rf_q[dec_rs2] : '0;
   end
`endif

   // Illegal ops bypass the hazard check: they only need a free issue slot
   always_comb begin
      hazard      = dec_legal & (busy_eff[dec_rs1] | (dec_is_r & busy_eff[dec_rs2]) | busy_eff[dec_rd]);
      slot_free   = !issue_valid_q | bus.issue_ready_i;
      instr_ready = slot_free & !hazard;
      accept      = bus.instr_valid_i & instr_ready;
   end

   always_comb begin
      issue_valid_d = issue_valid_q & !bus.issue_ready_i;
      rs1_data_d    = rs1_data_q;
      rs2_data_d    = rs2_data_q;
      imm_d         = imm_q;
      op_d          = op_q;
      func4_d       = func4_q;
      rd_d          = rd_q;
      illegal_d     = 1'b0;
      if (accept) begin
         if (dec_legal) begin
            issue_valid_d = 1'b1;
            rs1_data_d    = rs1_val;
            rs2_data_d    = rs2_val;
            imm_d         = dec_imm;
            op_d          = dec_op;
            func4_d       = dec_func4;
            rd_d          = dec_rd;
         end else begin
            illegal_d     = 1'b1;
         end
      end
   end

   // Scoreboard: a new producer's set wins over a same-cycle clear
   always_comb begin
      busy_d = busy_q & ~wb_clr_mask;
      if (accept && dec_legal && (dec_rd != '0)) busy_d[dec_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q        <= '0;
         issue_valid_q <= 1'b0;
         rs1_data_q    <= '0;
         rs2_data_q    <= '0;
         imm_q         <= '0;
         op_q          <= '0;
         func4_q       <= '0;
         rd_q          <= '0;
         illegal_q     <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         issue_valid_q <= issue_valid_d;
         rs1_data_q    <= rs1_data_d;
         rs2_data_q    <= rs2_data_d;
         imm_q         <= imm_d;
         op_q          <= op_d;
         func4_q       <= func4_d;
         rd_q          <= rd_d;
         illegal_q     <= illegal_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
      end else if (bus.wb_valid_i && (bus.wb_rd_i != '0)) begin
         rf_q[bus.wb_rd_i] <= bus.wb_data_i;
      end
   end

   assign bus.instr_ready_o = instr_ready;
   assign bus.issue_valid_o = issue_valid_q;
   assign bus.rs1_data_o    = rs1_data_q;
   assign bus.rs2_data_o    = rs2_data_q;
   assign bus.imm_o         = imm_q;
   assign bus.op_o          = op_q;
   assign bus.func4_o       = func4_q;
   assign bus.rd_o          = rd_q;
   assign bus.illegal_o     = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: vector table plus backpressure, illegal, RAW and reset sequences.
module tb_alu_issue;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   alu_issue_if bus ();
   alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [15:0] ins;
      logic        ir;
      logic        wv;
      logic [2:0]  wr;
      logic [15:0] wd;
      logic        e_rdy;
      logic        e_iv;
      logic [15:0] e_rs1;
      logic [15:0] e_rs2;
      logic [5:0]  e_imm;
      logic [2:0]  e_op;
      logic [3:0]  e_f;
      logic [2:0]  e_rd;
      logic        e_ill;
   } vec_t;

   function automatic logic [15:0] enc_r(logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2, logic [3:0] f);
      return {3'b000, rd, rs1, rs2, f};
   endfunction

   function automatic logic [15:0] enc_i(logic [2:0] rd, logic [2:0] rs1, logic [5:0] imm);
      return {3'b001, rd, rs1, imm, 1'b0};
   endfunction

   function automatic vec_t mk(logic v, logic [15:0] ins, logic ir, logic wv, logic [2:0] wr,
                               logic [15:0] wd, logic e_rdy, logic e_iv, logic [15:0] e_rs1,
                               logic [15:0] e_rs2, logic [5:0] e_imm, logic [2:0] e_op,
                               logic [3:0] e_f, logic [2:0] e_rd, logic e_ill);
      vec_t t;
      t.v = v; t.ins = ins; t.ir = ir; t.wv = wv; t.wr = wr; t.wd = wd;
      t.e_rdy = e_rdy; t.e_iv = e_iv; t.e_rs1 = e_rs1; t.e_rs2 = e_rs2; t.e_imm = e_imm;
      t.e_op = e_op; t.e_f = e_f; t.e_rd = e_rd; t.e_ill = e_ill;
      return t;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive after negedge, check ready before posedge, check registers after it
   task automatic step(input vec_t t, input string tag);
      @(negedge clk);
      bus.instr_valid_i = t.v;
      bus.instr_i       = t.ins;
      bus.issue_ready_i = t.ir;
      bus.wb_valid_i    = t.wv;
      bus.wb_rd_i       = t.wr;
      bus.wb_data_i     = t.wd;
      #1;
      chk({tag, ".instr_ready"}, 16'(bus.instr_ready_o), 16'(t.e_rdy));
      @(posedge clk);
      #1;
      chk({tag, ".issue_valid"}, 16'(bus.issue_valid_o), 16'(t.e_iv));
      chk({tag, ".illegal"},     16'(bus.illegal_o),     16'(t.e_ill));
      chk({tag, ".rs1"},         bus.rs1_data_o,         t.e_rs1);
      chk({tag, ".rs2"},         bus.rs2_data_o,         t.e_rs2);
      chk({tag, ".imm"},         16'(bus.imm_o),         16'(t.e_imm));
      chk({tag, ".op"},          16'(bus.op_o),          16'(t.e_op));
      chk({tag, ".func4"},       16'(bus.func4_o),       16'(t.e_f));
      chk({tag, ".rd"},          16'(bus.rd_o),          16'(t.e_rd));
   endtask

   vec_t tbl [12];
   logic [15:0] ins_illegal;
   logic [15:0] ins_raw;

   initial begin
      rst = 1'b1;
      bus.instr_valid_i = 1'b0;
      bus.instr_i       = '0;
      bus.issue_ready_i = 1'b1;
      bus.wb_valid_i    = 1'b0;
      bus.wb_rd_i       = '0;
      bus.wb_data_i     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.issue_valid", 16'(bus.issue_valid_o), 16'h0);
      chk("reset.rs1",         bus.rs1_data_o,         16'h0);
      chk("reset.illegal",     16'(bus.illegal_o),     16'h0);
      @(negedge clk);
      rst = 1'b0;

      //             v  ins                    ir wv wr  wd       rdy iv rs1      rs2      imm    op f     rd ill
      tbl[0]  = mk(0, 16'h0,                  1, 1, 3, 16'h0010, 1, 0, 16'h0,   16'h0,   6'h0,  0, 4'h0, 0, 0);
      tbl[1]  = mk(0, 16'h0,                  1, 1, 4, 16'h0005, 1, 0, 16'h0,   16'h0,   6'h0,  0, 4'h0, 0, 0);
      tbl[2]  = mk(1, enc_i(1, 0, 6'h3F),     1, 0, 0, 16'h0,    1, 1, 16'h0,   16'h0,   6'h3F, 1, 4'h0, 1, 0);
      tbl[3]  = mk(1, enc_r(5, 3, 4, 4'h7),   1, 0, 0, 16'h0,    1, 1, 16'h0010, 16'h0005, 6'h0, 0, 4'h7, 5, 0);
      tbl[4]  = mk(1, enc_i(6, 4, 6'h02),     1, 0, 0, 16'h0,    1, 1, 16'h0005, 16'h0,  6'h02, 1, 4'h0, 6, 0);
      tbl[5]  = mk(1, 16'hE000,               1, 0, 0, 16'h0,    1, 0, 16'h0005, 16'h0,  6'h02, 1, 4'h0, 6, 1);
      tbl[6]  = mk(0, 16'h0,                  1, 0, 0, 16'h0,    1, 0, 16'h0005, 16'h0,  6'h02, 1, 4'h0, 6, 0);
      tbl[7]  = mk(1, enc_r(2, 1, 0, 4'h0),   1, 0, 0, 16'h0,    0, 0, 16'h0005, 16'h0,  6'h02, 1, 4'h0, 6, 0);
      tbl[8]  = mk(0, 16'h0,                  1, 1, 1, 16'h00AA, 1, 0, 16'h0005, 16'h0,  6'h02, 1, 4'h0, 6, 0);
      tbl[9]  = mk(1, enc_r(2, 1, 0, 4'h0),   1, 0, 0, 16'h0,    1, 1, 16'h00AA, 16'h0,  6'h0,  0, 4'h0, 2, 0);
      tbl[10] = mk(1, enc_i(0, 0, 6'h01),     1, 1, 0, 16'hFFFF, 1, 1, 16'h0,   16'h0,   6'h01, 1, 4'h0, 0, 0);
      tbl[11] = mk(1, enc_i(0, 0, 6'h05),     1, 0, 0, 16'h0,    1, 1, 16'h0,   16'h0,   6'h05, 1, 4'h0, 0, 0);

      for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

      // Backpressure: issue slot held for 3 cycles, then the waiting instr goes through
      for (int i = 0; i < 3; i++)
         step(mk(1, enc_r(7, 0, 0, 4'h1), 0, 0, 0, 16'h0, 0, 1, 16'h0, 16'h0, 6'h05, 1, 4'h0, 0, 0),
              $sformatf("bp_hold%0d", i));
      step(mk(1, enc_r(7, 0, 0, 4'h1), 1, 0, 0, 16'h0, 1, 1, 16'h0, 16'h0, 6'h0, 0, 4'h1, 7, 0), "bp_release");
      step(mk(0, 16'h0, 1, 0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 6'h0, 0, 4'h1, 7, 0), "bp_drain");

      // Illegal op naming busy r5 is still consumed; r5 stays busy afterwards
      ins_illegal = {3'b111, 3'd5, 3'd5, 7'd0};
      step(mk(1, ins_illegal, 1, 0, 0, 16'h0, 1, 0, 16'h0, 16'h0, 6'h0, 0, 4'h1, 7, 1), "ill_busy");
      step(mk(1, enc_r(4, 5, 0, 4'h0), 1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 6'h0, 0, 4'h1, 7, 0), "ill_keep_busy");

      // RAW on r2 (busy since vec9) resolved by writeback of 16'h1234
      ins_raw = enc_r(3, 2, 2, 4'h2);
      step(mk(1, ins_raw, 1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 6'h0, 0, 4'h1, 7, 0), "raw_stall");
`ifdef ALU_ISSUE_BYPASS_EN
      step(mk(1, ins_raw, 1, 1, 2, 16'h1234, 1, 1, 16'h1234, 16'h1234, 6'h0, 0, 4'h2, 3, 0), "raw_fwd");
`else
      step(mk(1, ins_raw, 1, 1, 2, 16'h1234, 0, 0, 16'h0, 16'h0, 6'h0, 0, 4'h1, 7, 0), "raw_wb");
      step(mk(1, ins_raw, 1, 0, 0, 16'h0, 1, 1, 16'h1234, 16'h1234, 6'h0, 0, 4'h2, 3, 0), "raw_read");
`endif

      // Reset while the RAW result sits stalled in the issue slot
      step(mk(0, 16'h0, 0, 0, 0, 16'h0, 0, 1, 16'h1234, 16'h1234, 6'h0, 0, 4'h2, 3, 0), "pre_rst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst.issue_valid", 16'(bus.issue_valid_o), 16'h0);
      chk("midrst.rs1",         bus.rs1_data_o,         16'h0);
      chk("midrst.rd",          16'(bus.rd_o),          16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      // r5/r7 were busy before reset; r1/r2 held data
      step(mk(1, enc_r(6, 5, 5, 4'h0), 1, 0, 0, 16'h0, 1, 1, 16'h0, 16'h0, 6'h0, 0, 4'h0, 6, 0), "post_rst_busy");
      step(mk(1, enc_r(1, 1, 2, 4'h3), 1, 0, 0, 16'h0, 1, 1, 16'h0, 16'h0, 6'h0, 0, 4'h3, 1, 0), "post_rst_rf");
      step(mk(1, enc_i(4, 7, 6'h11), 1, 0, 0, 16'h0, 1, 1, 16'h0, 16'h0, 6'h11, 1, 4'h0, 4, 0), "post_rst_r7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
